// File: rtl/mem_access.sv
// mem_access: MEM stage of the pipeline. Issues at most one load/store per
// EX/MEM instruction to a handshaked memory, stalls the earlier stages until
// memAck arrives, and fills the MEM/WB register.
//
// Ports
//   clk, reset (async, active-low)
//   exmem*      : EX/MEM register contents (address/result, store data, R15,
//                 opcodes, writeback control, W/R/SB/F controls)
//   memReq/memWe/memAddr/memBe/memWdata : registered request to memory
//   memRdata/memAck : memory response
//   stall       : combinational hold for EX/MEM and earlier stages
//   alignErr    : registered pulse for a misaligned word access
//   memwb*      : MEM/WB register outputs
module mem_access (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] exmemALUout,
    input  logic [15:0] exmemRD1,
    input  logic [15:0] exmemRD15,
    input  logic [3:0]  exmemOP1,
    input  logic [3:0]  exmemOP2,
    input  logic [2:0]  exmemregWrite,
    input  logic        exmemW,
    input  logic        exmemR,
    input  logic        exmemSB,
    input  logic        exmemF,
    output logic        memReq,
    output logic        memWe,
    output logic [15:0] memAddr,
    output logic [15:0] memWdata,
    output logic [1:0]  memBe,
    input  logic [15:0] memRdata,
    input  logic        memAck,
    output logic        stall,
    output logic        alignErr,
    output logic [15:0] memwbResult,
    output logic [15:0] memwbRD15,
    output logic [3:0]  memwbOP1,
    output logic [3:0]  memwbOP2,
    output logic [2:0]  memwbregWrite,
    output logic        memwbF,
    output logic        memwbValid
);

    localparam int unsigned DW = 16;
    localparam int unsigned BW = 8;

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t          state_q, state_d;
    logic            req_q, req_d, we_q, we_d;
    logic [DW-1:0]   addr_q, addr_d, wdata_q, wdata_d;
    logic [1:0]      be_q, be_d;
    logic            sb_q, sb_d, lsb_q, lsb_d;
    logic            align_q, align_d;
    logic [DW-1:0]   res_q, res_d, rd15_q, rd15_d;
    logic [3:0]      op1_q, op1_d, op2_q, op2_d;
    logic [2:0]      rw_q, rw_d;
    logic            f_q, f_d, valid_q, valid_d;

    logic            misaligned_c, access_c, stall_c;
    logic [BW-1:0]   rbyte_c;
    logic [DW-1:0]   load_data_c;

    // Only a memory op can be misaligned; byte accesses never are.
    assign misaligned_c = (exmemR | exmemW) & ~exmemSB & exmemALUout[0];
    assign access_c     = (exmemR | exmemW) & ~misaligned_c;

    // Load return: full word, or the addressed byte sign-extended.
    assign rbyte_c     = lsb_q ? memRdata[DW-1:BW] : memRdata[BW-1:0];
    assign load_data_c = sb_q ? {{(DW-BW){rbyte_c[BW-1]}}, rbyte_c} : memRdata;

    // Next-state, request and MEM/WB load logic.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        sb_d    = sb_q;
        lsb_d   = lsb_q;
        align_d = 1'b0;
        res_d   = res_q;
        rd15_d  = rd15_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        rw_d    = rw_q;
        f_d     = f_q;
        valid_d = valid_q;
        stall_c = 1'b0;

        case (state_q)
            IDLE: begin
                if (access_c) begin
                    stall_c = 1'b1;
                    state_d = BUSY;
                    req_d   = 1'b1;
                    we_d    = exmemW;
                    addr_d  = {exmemALUout[DW-1:1], 1'b0};
                    be_d    = exmemSB ? (exmemALUout[0] ? 2'b10 : 2'b01) : 2'b11;
                    wdata_d = exmemSB ? {exmemRD1[BW-1:0], exmemRD1[BW-1:0]} : exmemRD1;
                    sb_d    = exmemSB;
                    lsb_d   = exmemALUout[0];
                end else begin
                    align_d = misaligned_c;
                    res_d   = exmemALUout;
                    rd15_d  = exmemRD15;
                    op1_d   = exmemOP1;
                    op2_d   = exmemOP2;
                    rw_d    = misaligned_c ? 3'b000 : exmemregWrite;
                    f_d     = exmemF;
                    valid_d = 1'b1;
                end
            end
            BUSY: begin
                stall_c = ~memAck;
                if (memAck) begin
                    // Drop the request on ack so it can never be reissued.
                    state_d = IDLE;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    addr_d  = '0;
                    wdata_d = '0;
                    be_d    = 2'b00;
                    res_d   = we_q ? exmemALUout : load_data_c;
                    rd15_d  = exmemRD15;
                    op1_d   = exmemOP1;
                    op2_d   = exmemOP2;
                    rw_d    = we_q ? 3'b000 : exmemregWrite;
                    f_d     = exmemF;
                    valid_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Stalled edges push a bubble into MEM/WB.
        if (stall_c) begin
            valid_d = 1'b0;
            rw_d    = 3'b000;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= 2'b00;
            sb_q    <= 1'b0;
            lsb_q   <= 1'b0;
            align_q <= 1'b0;
            res_q   <= '0;
            rd15_q  <= '0;
            op1_q   <= '0;
            op2_q   <= '0;
            rw_q    <= '0;
            f_q     <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            sb_q    <= sb_d;
            lsb_q   <= lsb_d;
            align_q <= align_d;
            res_q   <= res_d;
            rd15_q  <= rd15_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            rw_q    <= rw_d;
            f_q     <= f_d;
            valid_q <= valid_d;
        end
    end

    assign memReq        = req_q;
    assign memWe         = we_q;
    assign memAddr       = addr_q;
    assign memWdata      = wdata_q;
    assign memBe         = be_q;
    assign stall         = stall_c;
    assign alignErr      = align_q;
    assign memwbResult   = res_q;
    assign memwbRD15     = rd15_q;
    assign memwbOP1      = op1_q;
    assign memwbOP2      = op2_q;
    assign memwbregWrite = rw_q;
    assign memwbF        = f_q;
    assign memwbValid    = valid_q;

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed cases followed by randomized
// ops, each compared against a transaction-level model of the MEM stage.
module tb_mem_access;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] exmemALUout, exmemRD1, exmemRD15;
    logic [3:0]  exmemOP1, exmemOP2;
    logic [2:0]  exmemregWrite;
    logic        exmemW, exmemR, exmemSB, exmemF;
    logic        memReq, memWe;
    logic [15:0] memAddr, memWdata;
    logic [1:0]  memBe;
    logic [15:0] memRdata;
    logic        memAck;
    logic        stall, alignErr;
    logic [15:0] memwbResult, memwbRD15;
    logic [3:0]  memwbOP1, memwbOP2;
    logic [2:0]  memwbregWrite;
    logic        memwbF, memwbValid;

    int          checks_total  = 0;
    int          checks_passed = 0;
    logic [15:0] prev_result;

    mem_access dut (
        .clk(clk), .reset(reset),
        .exmemALUout(exmemALUout), .exmemRD1(exmemRD1), .exmemRD15(exmemRD15),
        .exmemOP1(exmemOP1), .exmemOP2(exmemOP2), .exmemregWrite(exmemregWrite),
        .exmemW(exmemW), .exmemR(exmemR), .exmemSB(exmemSB), .exmemF(exmemF),
        .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memWdata(memWdata),
        .memBe(memBe), .memRdata(memRdata), .memAck(memAck),
        .stall(stall), .alignErr(alignErr),
        .memwbResult(memwbResult), .memwbRD15(memwbRD15),
        .memwbOP1(memwbOP1), .memwbOP2(memwbOP2), .memwbregWrite(memwbregWrite),
        .memwbF(memwbF), .memwbValid(memwbValid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_total++;
        assert (obs === exp) checks_passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Presents one EX/MEM instruction (caller is at a negedge) and follows it
    // to MEM/WB. wait_n = cycles the memory withholds ack after BUSY entry.
    task automatic do_op(input logic w, input logic r, input logic sb, input logic f,
                         input logic [15:0] alu, input logic [15:0] rd1,
                         input logic [15:0] rd15, input logic [3:0] op1,
                         input logic [3:0] op2, input logic [2:0] rw,
                         input int wait_n, input logic [15:0] rdata);
        logic               mis, acc, ack;
        logic [15:0]        exp_addr, exp_wd, exp_res;
        logic [1:0]         exp_be;
        logic [2:0]         exp_rw;
        logic [7:0]         b;
        logic signed [15:0] sx;
        mis      = (r || w) && !sb && alu[0];
        acc      = (r || w) && !mis;
        exp_addr = alu & 16'hFFFE;
        exp_be   = sb ? (2'b01 << alu[0]) : 2'b11;
        exp_wd   = sb ? 16'(rd1[7:0]) * 16'h0101 : rd1;
        b        = 8'(rdata >> (alu[0] ? 8 : 0));
        sx       = $signed(b);
        exp_res  = (acc && r && !w) ? (sb ? 16'(sx) : rdata) : alu;
        exp_rw   = (w || mis) ? 3'b000 : rw;

        exmemW = w; exmemR = r; exmemSB = sb; exmemF = f;
        exmemALUout = alu; exmemRD1 = rd1; exmemRD15 = rd15;
        exmemOP1 = op1; exmemOP2 = op2; exmemregWrite = rw;
        memAck = 1'b0; memRdata = 16'($urandom);
        #1;
        chk("stall_first", 32'(stall), 32'(acc));
        chk("req_idle", 32'(memReq), 32'h0);
        if (acc) begin
            for (int c = 0; c <= wait_n; c++) begin
                @(negedge clk);
                ack    = (c == wait_n);
                memAck = ack;
                memRdata = ack ? rdata : 16'($urandom);
                #1;
                chk("req_busy", 32'(memReq), 32'h1);
                chk("we", 32'(memWe), 32'(w));
                chk("addr", 32'(memAddr), 32'(exp_addr));
                chk("be", 32'(memBe), 32'(exp_be));
                chk("wdata", 32'(memWdata), 32'(exp_wd));
                chk("stall_busy", 32'(stall), 32'(!ack));
                chk("bubble_valid", 32'(memwbValid), 32'h0);
                chk("bubble_rw", 32'(memwbregWrite), 32'h0);
                chk("bubble_hold", 32'(memwbResult), 32'(prev_result));
            end
        end
        @(negedge clk);
        memAck = 1'b0;
        #1;
        chk("req_done", 32'(memReq), 32'h0);
        chk("we_done", 32'(memWe), 32'h0);
        chk("wb_result", 32'(memwbResult), 32'(exp_res));
        chk("wb_rd15", 32'(memwbRD15), 32'(rd15));
        chk("wb_ops", 32'({memwbOP1, memwbOP2}), 32'({op1, op2}));
        chk("wb_rw", 32'(memwbregWrite), 32'(exp_rw));
        chk("wb_f", 32'(memwbF), 32'(f));
        chk("wb_valid", 32'(memwbValid), 32'h1);
        chk("align_err", 32'(alignErr), 32'(mis));
        prev_result = exp_res;
    endtask

    initial begin
        logic [1:0] k;
        reset = 1'b0;
        exmemW = 0; exmemR = 0; exmemSB = 0; exmemF = 0;
        exmemALUout = 0; exmemRD1 = 0; exmemRD15 = 0;
        exmemOP1 = 0; exmemOP2 = 0; exmemregWrite = 0;
        memAck = 0; memRdata = 0;
        prev_result = 16'h0000;
        #1;
        chk("rst_req", 32'({memReq, memWe, alignErr, memwbValid}), 32'h0);
        chk("rst_mem", 32'({memAddr, memWdata}), 32'h0);
        chk("rst_be", 32'(memBe), 32'h0);
        chk("rst_wb", 32'({memwbResult, memwbRD15}), 32'h0);
        chk("rst_wbctl", 32'({memwbOP1, memwbOP2, memwbregWrite, memwbF}), 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Pass-through, word load with one wait, byte store, byte loads,
        // misaligned word store, store+load collision.
        do_op(0, 0, 0, 0, 16'hA0A0, 16'h0000, 16'h0098, 4'h1, 4'h0, 3'b010, 0, 16'h0000);
        do_op(0, 1, 0, 1, 16'h1BEA, 16'h0000, 16'h0055, 4'h3, 4'h2, 3'b011, 1, 16'hBEEF);
        do_op(1, 0, 1, 0, 16'h0A0B, 16'h0A0A, 16'h0001, 4'h4, 4'h1, 3'b001, 0, 16'h0000);
        do_op(0, 1, 1, 0, 16'h0010, 16'h0000, 16'h0002, 4'h5, 4'h1, 3'b100, 0, 16'h1280);
        do_op(0, 1, 1, 0, 16'h0011, 16'h0000, 16'h0003, 4'h5, 4'h1, 3'b100, 2, 16'h1280);
        do_op(1, 0, 0, 0, 16'h0A0B, 16'h1234, 16'h0004, 4'h6, 4'h0, 3'b010, 0, 16'h0000);
        do_op(0, 0, 0, 1, 16'h7777, 16'h0000, 16'h0005, 4'h2, 4'h2, 3'b111, 0, 16'h0000);
        do_op(1, 1, 0, 0, 16'h0200, 16'hCAFE, 16'h0006, 4'h7, 4'h3, 3'b110, 0, 16'h9999);

        // Reset while BUSY without ack.
        exmemW = 0; exmemR = 1; exmemSB = 0; exmemALUout = 16'h0100;
        exmemregWrite = 3'b001; memAck = 0;
        @(negedge clk);
        #1;
        chk("rst_busy_req", 32'(memReq), 32'h1);
        #2;
        reset = 1'b0;
        #1;
        chk("rst_async_req", 32'({memReq, memWe}), 32'h0);
        chk("rst_async_wb", 32'({memwbResult, memwbValid, memwbregWrite}), 32'h0);
        exmemR = 0;
        @(negedge clk);
        reset = 1'b1;
        prev_result = 16'h0000;
        #1;
        chk("rst_release_req", 32'(memReq), 32'h0);
        do_op(0, 0, 0, 0, 16'h4242, 16'h0000, 16'h0007, 4'h1, 4'h1, 3'b001, 0, 16'h0000);

        // Randomized ops.
        for (int i = 0; i < 40; i++) begin
            k = 2'($urandom_range(0, 3));
            do_op(k[1], k[0], 1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom),
                  16'($urandom), 4'($urandom), 4'($urandom), 3'($urandom),
                  int'($urandom_range(0, 3)), 16'($urandom));
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
